// File: rtl/blake2_cmd_tx.sv
// blake2_cmd_tx
//   Host-side transmitter for the BLAKE2 byte-serial command interface.
//   A job has three phases. First, kk, nn and the 64-bit ll are sent as 10
//   CONF bytes. Next come the key block (when kk != 0) and the message
//   blocks, each 64 bytes long and zero padded, marked with START, DATA or
//   LAST. Finally, optionally, the device's hash bytes are forwarded back.
//
//   Optional feature macro: BLAKE2_CMD_TX_HASH_CAPTURE_EN
//     defined   : a HASH state forwards hash_v_i/hash_i with 1-cycle latency
//                 and flags the nn-th byte on hash_last_o
//     undefined : hash_* outputs are tied to 0 and DONE follows the last block
//
// Ports
//   clk, nreset                 clock, synchronous active-low reset
//   start_i, kk_i, nn_i, ll_i   job start pulse and job parameters
//   busy_o, done_o              job in progress / one-cycle end-of-job pulse
//   msg_valid_i/msg_data_i/msg_ready_o   upstream key+message byte stream
//   dev_ready_i                 device ready for the next block
//   tx_valid_o/tx_cmd_o/tx_data_o        byte stream to the device
//   hash_v_i/hash_i             hash bytes returned by the device
//   hash_valid_o/hash_data_o/hash_last_o forwarded hash bytes
module blake2_cmd_tx #(
  parameter int BLOCK_BYTES = 64
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        msg_valid_i,
  input  logic [7:0]  msg_data_i,
  output logic        msg_ready_o,
  input  logic        dev_ready_i,
  output logic        tx_valid_o,
  output logic [1:0]  tx_cmd_o,
  output logic [7:0]  tx_data_o,
  input  logic        hash_v_i,
  input  logic [7:0]  hash_i,
  output logic        hash_valid_o,
  output logic [7:0]  hash_data_o,
  output logic        hash_last_o
);

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;
  localparam logic [5:0] LAST_IDX  = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] CONF_LAST = 6'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_WAIT,
    S_BLOCK,
`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
    S_HASH,
`endif
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [79:0] conf_q, conf_d;       // CONF bytes, shifted out LSB first
  logic [5:0]  kk_q, kk_d;
  logic [63:0] rem_q, rem_d;         // message bytes still to consume
  logic [63:0] blk_q, blk_d;         // blocks left, including the current one
  logic        first_q, first_d;
  logic        key_q, key_d;         // current block is the key block
  logic        tx_valid_q, tx_valid_d;
  logic [1:0]  tx_cmd_q, tx_cmd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] nb;
  logic        stream_byte;
  logic        last_blk;
  logic [1:0]  byte_cmd;

`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
  logic [5:0]  nn_q, nn_d;
  logic [5:0]  hcnt_q, hcnt_d;
  logic        hlast_q, hlast_d;     // nn-th hash byte already forwarded
  logic        hash_valid_q, hash_valid_d;
  logic [7:0]  hash_data_q, hash_data_d;
  logic        hash_last_q, hash_last_d;
`endif

  // Job size in blocks; an empty job still sends one all-zero block.
  always_comb begin
    nb = 64'(kk_i != 6'd0) + (ll_i >> 6) + 64'(|ll_i[5:0]);
    if (nb == 64'd0) nb = 64'd1;
  end

  assign last_blk    = (blk_q == 64'd1);
  assign stream_byte = key_q ? (idx_q < kk_q) : (rem_q != 64'd0);
  assign msg_ready_o = (state_q == S_BLOCK) && stream_byte;

  always_comb begin
    byte_cmd = CMD_DATA;
    if (idx_q == 6'd0)
      byte_cmd = first_q ? CMD_START : (last_blk ? CMD_LAST : CMD_DATA);
    else if (idx_q == 6'd1 && first_q && last_blk)
      byte_cmd = CMD_LAST;  // single-block job carries LAST on byte 1
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    conf_d     = conf_q;
    kk_d       = kk_q;
    rem_d      = rem_q;
    blk_d      = blk_q;
    first_d    = first_q;
    key_d      = key_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_valid_d = 1'b0;
    tx_cmd_d   = CMD_CONF;
    tx_data_d  = 8'h00;
`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
    nn_d         = nn_q;
    hcnt_d       = hcnt_q;
    hlast_d      = hlast_q;
    hash_valid_d = 1'b0;
    hash_data_d  = 8'h00;
    hash_last_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          conf_d  = {ll_i, 2'b00, nn_i, 2'b00, kk_i};
          kk_d    = kk_i;
          rem_d   = ll_i;
          blk_d   = nb;
          first_d = 1'b1;
          key_d   = (kk_i != 6'd0);
          idx_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = S_CONF;
`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
          nn_d    = nn_i;
`endif
        end
      end
      S_CONF: begin
        tx_valid_d = 1'b1;
        tx_data_d  = conf_q[7:0];
        conf_d     = conf_q >> 8;
        idx_d      = idx_q + 6'd1;
        if (idx_q == CONF_LAST) begin
          idx_d   = 6'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dev_ready_i) begin
          idx_d   = 6'd0;
          state_d = S_BLOCK;
        end
      end
      S_BLOCK: begin
        // Pad bytes never stall; stream bytes wait for the handshake.
        if (!stream_byte || msg_valid_i) begin
          tx_valid_d = 1'b1;
          tx_cmd_d   = byte_cmd;
          tx_data_d  = stream_byte ? msg_data_i : 8'h00;
          if (stream_byte && !key_q) rem_d = rem_q - 64'd1;
          idx_d = idx_q + 6'd1;
          if (idx_q == LAST_IDX) begin
            idx_d = 6'd0;
            if (!last_blk) begin
              blk_d   = blk_q - 64'd1;
              first_d = 1'b0;
              key_d   = 1'b0;
              state_d = S_WAIT;
            end else begin
`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
              hcnt_d  = 6'd0;
              hlast_d = 1'b0;
              state_d = S_HASH;
`else
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
      S_HASH: begin
        if (hlast_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (hash_v_i) begin
          hash_valid_d = 1'b1;
          hash_data_d  = hash_i;
          hcnt_d       = hcnt_q + 6'd1;
          if ({1'b0, hcnt_q} + 7'd1 == {1'b0, nn_q}) begin
            hash_last_d = 1'b1;
            hlast_d     = 1'b1;
          end
        end
      end
`endif
      // done_o is high for exactly this state, so start_i here is dropped.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_cmd_q   <= 2'd0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Job context: always loaded on start before it is used.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    conf_q  <= conf_d;
    kk_q    <= kk_d;
    rem_q   <= rem_d;
    blk_q   <= blk_d;
    first_q <= first_d;
    key_q   <= key_d;
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_cmd_o   = tx_cmd_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

`ifdef BLAKE2_CMD_TX_HASH_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      hash_valid_q <= 1'b0;
      hash_data_q  <= 8'h00;
      hash_last_q  <= 1'b0;
    end else begin
      hash_valid_q <= hash_valid_d;
      hash_data_q  <= hash_data_d;
      hash_last_q  <= hash_last_d;
    end
  end

  always_ff @(posedge clk) begin
    nn_q    <= nn_d;
    hcnt_q  <= hcnt_d;
    hlast_q <= hlast_d;
  end

  assign hash_valid_o = hash_valid_q;
  assign hash_data_o  = hash_data_q;
  assign hash_last_o  = hash_last_q;
`else
  logic unused_hash;
  assign unused_hash  = ^{hash_v_i, hash_i};
  assign hash_valid_o = 1'b0;
  assign hash_data_o  = 8'h00;
  assign hash_last_o  = 1'b0;
`endif

endmodule
